// File: rtl/r2b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r2b_pkg
// Description : Shared types and helpers for the row-to-block converter:
//               FSM encoding, geometry derivation and the block-order mapping
//               from output element index to group-buffer position.
// Revision    : 1.0 - initial release
// ============================================================================
package r2b_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] group_rows;
    logic [31:0] slice_words;
    logic [31:0] num_groups;
  } geom_t;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
  } buf_pos_t;

  // Bit width needed to count n values; never narrower than one bit.
  function automatic int clog2_safe(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

  // Rows gathered per group, output words per group, and number of groups.
  function automatic geom_t derive_geom(input int row, input int col, input int bs,
                                        input int nch, input int ncv);
    geom_t g;
    g.group_rows  = 32'(ncv * bs);
    g.slice_words = 32'(col / (nch * bs));
    g.num_groups  = 32'(row / (ncv * bs));
    return g;
  endfunction

  // Element k of word j comes from buffer row nv*BS+r, column j*NCH*BS+nh*BS+e,
  // where k = nh*CHUNK*NCV + nv*CHUNK + r*BS + e.
  function automatic buf_pos_t map_index(input int k, input int j, input int bs,
                                         input int chunk, input int nch, input int ncv);
    buf_pos_t p;
    int nh, nv, r, e;
    nh    = k / (chunk * ncv);
    nv    = (k % (chunk * ncv)) / chunk;
    r     = (k % chunk) / bs;
    e     = k % bs;
    p.row = 32'(nv * bs + r);
    p.col = 32'(j * nch * bs + nh * bs + e);
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/r2b_converter_group_buffer.sv
`default_nettype none
// ============================================================================
// Module      : r2b_converter_group_buffer
// Description : Holds one row group (GROUP_ROWS full matrix rows) and presents
//               the selected core-mode output word combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module r2b_converter_group_buffer
  import r2b_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int COL         = 64,
  parameter int GROUP_ROWS  = 4,
  parameter int BLOCK_SIZE  = 2,
  parameter int CHUNK_SIZE  = 4,
  parameter int NUM_CORES_H = 2,
  parameter int NUM_CORES_V = 2,
  parameter int SLICE_WORDS = 16,
  parameter int SEL_W       = 5
) (
  input  logic                                      clk,
  input  logic                                      wr_en_i,
  input  logic [clog2_safe(GROUP_ROWS)-1:0]         wr_addr_i,
  input  logic [WIDTH*COL-1:0]                      wr_data_i,
  input  logic [SEL_W-1:0]                          word_sel_i,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES_H*NUM_CORES_V-1:0] word_o
);

  localparam int RW        = WIDTH * COL;
  localparam int AW        = clog2_safe(GROUP_ROWS);
  localparam int OUT_ELEMS = CHUNK_SIZE * NUM_CORES_H * NUM_CORES_V;
  localparam int NSEL      = 1 << SEL_W;

  logic [RW-1:0]            mem_q [GROUP_ROWS];
  logic [GROUP_ROWS*RW-1:0] flat;
  logic [WIDTH-1:0]         cand [OUT_ELEMS][NSEL];

  // Row storage: the accepted row lands in its slot; contents need no reset.
  always_ff @(posedge clk) begin
    for (int g = 0; g < GROUP_ROWS; g++) begin
      if (wr_en_i && (wr_addr_i == AW'(g))) begin
        mem_q[g] <= wr_data_i;
      end
    end
  end

  for (genvar g = 0; g < GROUP_ROWS; g++) begin : g_row
    assign flat[g*RW +: RW] = mem_q[g];
  end

  // Each output element picks from a fixed candidate per word index, so the
  // mapping becomes constant wiring plus one mux per element.
  for (genvar k = 0; k < OUT_ELEMS; k++) begin : g_elem
    for (genvar j = 0; j < NSEL; j++) begin : g_word
      if (j < SLICE_WORDS) begin : g_live
        localparam buf_pos_t POS = map_index(k, j, BLOCK_SIZE, CHUNK_SIZE,
                                             NUM_CORES_H, NUM_CORES_V);
        localparam int BIT = (int'(POS.row) * COL + int'(POS.col)) * WIDTH;
        assign cand[k][j] = flat[BIT +: WIDTH];
      end else begin : g_pad
        assign cand[k][j] = '0;
      end
    end
    assign word_o[k*WIDTH +: WIDTH] = cand[k][word_sel_i];
  end

endmodule
`default_nettype wire

// File: rtl/r2b_converter.sv
`default_nettype none
// ============================================================================
// Module      : r2b_converter
// Description : Row-to-block converter. Collects one row group of a row-major
//               matrix, then streams it out in core-mode block order, one
//               word per handshake, to feed the systolic core array.
// Revision    : 1.0 - initial release
// ============================================================================
module r2b_converter
  import r2b_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FRAC_WIDTH  = 8,
  parameter int ROW         = 256,
  parameter int COL         = 64,
  parameter int BLOCK_SIZE  = 2,
  parameter int CHUNK_SIZE  = 4,
  parameter int NUM_CORES_H = 2,
  parameter int NUM_CORES_V = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 en,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [WIDTH*COL-1:0]                                 in_data,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES_H*NUM_CORES_V-1:0]  out_data,
  output logic                                                 out_slice_last,
  output logic                                                 out_last,
  output logic                                                 done
);

  localparam geom_t GEOM        = derive_geom(ROW, COL, BLOCK_SIZE, NUM_CORES_H, NUM_CORES_V);
  localparam int    GROUP_ROWS  = int'(GEOM.group_rows);
  localparam int    SLICE_WORDS = int'(GEOM.slice_words);
  localparam int    NUM_GROUPS  = int'(GEOM.num_groups);
  localparam int    OUT_W       = WIDTH * CHUNK_SIZE * NUM_CORES_H * NUM_CORES_V;
  localparam int    RC_W        = clog2_safe(GROUP_ROWS);
  // word_cnt must be able to reach SLICE_WORDS to mark the group exhausted.
  localparam int    WC_W        = clog2_safe(SLICE_WORDS + 1);
  localparam int    GC_W        = clog2_safe(NUM_GROUPS);

  localparam logic [RC_W-1:0] ROW_LAST  = RC_W'(GROUP_ROWS - 1);
  localparam logic [WC_W-1:0] WORD_END  = WC_W'(SLICE_WORDS);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(SLICE_WORDS - 1);
  localparam logic [GC_W-1:0] GRP_LAST  = GC_W'(NUM_GROUPS - 1);

  // Reject geometries the block mapping cannot represent.
  if ((CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) ||
      (ROW % GROUP_ROWS != 0) ||
      (COL % (NUM_CORES_H * BLOCK_SIZE) != 0) ||
      (FRAC_WIDTH > WIDTH)) begin : g_param_check
    $error("r2b_converter: illegal parameter combination");
  end

  state_e            state_q, state_d;
  logic [RC_W-1:0]   row_cnt_q, row_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [GC_W-1:0]   grp_cnt_q, grp_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              slice_last_q, slice_last_d;
  logic              last_q, last_d;
  logic              wr_en;
  logic              xfer;
  logic [OUT_W-1:0]  buf_word;

  r2b_converter_group_buffer #(
    .WIDTH       (WIDTH),
    .COL         (COL),
    .GROUP_ROWS  (GROUP_ROWS),
    .BLOCK_SIZE  (BLOCK_SIZE),
    .CHUNK_SIZE  (CHUNK_SIZE),
    .NUM_CORES_H (NUM_CORES_H),
    .NUM_CORES_V (NUM_CORES_V),
    .SLICE_WORDS (SLICE_WORDS),
    .SEL_W       (WC_W)
  ) u_buf (
    .clk        (clk),
    .wr_en_i    (wr_en),
    .wr_addr_i  (row_cnt_q),
    .wr_data_i  (in_data),
    .word_sel_i (word_cnt_q),
    .word_o     (buf_word)
  );

  // State, counters and the output register; reset aborts any partial group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      word_cnt_q   <= '0;
      grp_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      slice_last_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      word_cnt_q   <= word_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      slice_last_q <= slice_last_d;
      last_q       <= last_d;
    end
  end

  // Next-state, row capture and output-word loading; en low freezes all.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    word_cnt_d   = word_cnt_q;
    grp_cnt_d    = grp_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    slice_last_d = slice_last_q;
    last_d       = last_q;
    in_ready     = 1'b0;
    wr_en        = 1'b0;
    xfer         = out_valid_q & out_ready & en;

    case (state_q)
      IDLE: begin
        if (en) state_d = FILL;
      end
      FILL: begin
        in_ready = en;
        if (en && in_valid) begin
          wr_en = 1'b1;
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d  = '0;
            word_cnt_d = '0;
            state_d    = EMIT;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (xfer) begin
          out_valid_d  = 1'b0;
          slice_last_d = 1'b0;
          last_d       = 1'b0;
        end
        // A new word may replace the current one on the same edge it leaves.
        if (en && (word_cnt_q < WORD_END) && (!out_valid_q || out_ready)) begin
          out_valid_d  = 1'b1;
          out_data_d   = buf_word;
          slice_last_d = (word_cnt_q == WORD_LAST);
          last_d       = (word_cnt_q == WORD_LAST) && (grp_cnt_q == GRP_LAST);
          word_cnt_d   = word_cnt_q + 1'b1;
        end
        if (xfer && slice_last_q) begin
          if (grp_cnt_q == GRP_LAST) begin
            state_d = DONE;
          end else begin
            grp_cnt_d = grp_cnt_q + 1'b1;
            state_d   = FILL;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_slice_last = slice_last_q;
  assign out_last       = last_q;
  assign done           = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_r2b_converter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_r2b_converter
// Description : Self-checking bench for r2b_converter with a reference model
//               computed directly from the block-order mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r2b_converter;

  localparam int W     = 16;
  localparam int ROWS  = 256;
  localparam int COLS  = 64;
  localparam int BS    = 2;
  localparam int CH    = 4;
  localparam int NCH   = 2;
  localparam int NCV   = 2;
  localparam int GR    = NCV * BS;
  localparam int SW    = COLS / (NCH * BS);
  localparam int NG    = ROWS / GR;
  localparam int TOTAL = NG * SW;
  localparam int EL    = CH * NCH * NCV;
  localparam int OW    = W * EL;
  localparam int BOUND = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en, in_valid, in_ready, out_valid, out_ready;
  logic [W*COLS-1:0] in_data;
  logic [OW-1:0]   out_data;
  logic            out_slice_last, out_last, done;

  logic            s_rst, s_en, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [63:0]     s_in_data, s_out_data;
  logic            s_out_slice_last, s_out_last, s_done;

  r2b_converter #(
    .WIDTH(W), .FRAC_WIDTH(8), .ROW(ROWS), .COL(COLS), .BLOCK_SIZE(BS),
    .CHUNK_SIZE(CH), .NUM_CORES_H(NCH), .NUM_CORES_V(NCV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_slice_last(out_slice_last), .out_last(out_last),
    .done(done)
  );

  r2b_converter #(
    .WIDTH(16), .FRAC_WIDTH(8), .ROW(4), .COL(4), .BLOCK_SIZE(2),
    .CHUNK_SIZE(4), .NUM_CORES_H(1), .NUM_CORES_V(1)
  ) dut_s (
    .clk(clk), .rst(s_rst), .en(s_en), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_slice_last(s_out_slice_last), .out_last(s_out_last),
    .done(s_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: observed %0h required %0h", tag, obs, expv);
  endtask

  // Reference matrix and block-order model.
  int mode = 0;
  int seed = 0;

  function automatic logic [W-1:0] mval(input int r, input int c);
    if (mode == 0) return W'(r * COLS + c);
    return W'(r * 37 + c * 1013 + seed + r * c);
  endfunction

  function automatic logic [W*COLS-1:0] row_vec(input int r);
    logic [W*COLS-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*W +: W] = mval(r, c);
    return v;
  endfunction

  function automatic logic [OW-1:0] exp_word(input int n);
    logic [OW-1:0] w;
    int s, j, nh, nv, rr, e;
    s = n / SW;
    j = n % SW;
    for (int k = 0; k < EL; k++) begin
      nh = k / (CH * NCV);
      nv = (k % (CH * NCV)) / CH;
      rr = (k % CH) / BS;
      e  = k % BS;
      w[k*W +: W] = mval(s * GR + nv * BS + rr, j * NCH * BS + nh * BS + e);
    end
    return w;
  endfunction

  // Row feeder: presents rows in order, optional gaps, junk after the last row.
  int feed_row    = 0;
  bit feed_active = 1'b0;
  bit acc_seen    = 1'b0;
  int gap_pct     = 0;
  int ready_pct   = 100;

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (acc_seen) feed_row++;
      acc_seen = 1'b0;
      if (!feed_active) begin
        in_valid = 1'b0;
      end else if (feed_row >= ROWS) begin
        in_valid = 1'b1;
        in_data  = {(W*COLS/32){$urandom}};
      end else if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = row_vec(feed_row);
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Output monitor, sampled mid-cycle.
  int exp_idx   = 0;
  int last_cnt  = 0;
  int slice_cnt = 0;
  bit hold_prev = 1'b0;
  logic [OW+2:0] prev_snap;
  logic [OW-1:0] cap_w0, cap_w1;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("hold", {out_valid, out_slice_last, out_last, out_data}, prev_snap);
      if (out_valid || !en)
        check("in_ready_low", in_ready, 1'b0);
      if (out_valid && out_ready && en) begin
        if (exp_idx >= TOTAL) begin
          check("extra_word", exp_idx, TOTAL - 1);
        end else begin
          check("word", out_data, exp_word(exp_idx));
          check("slice_last", out_slice_last, (exp_idx % SW) == SW - 1);
          check("last", out_last, exp_idx == TOTAL - 1);
        end
        if (exp_idx == 0) cap_w0 = out_data;
        if (exp_idx == 1) cap_w1 = out_data;
        if (out_last) last_cnt++;
        if (out_slice_last) slice_cnt++;
        exp_idx++;
      end
      if (in_valid && in_ready && en) acc_seen = 1'b1;
      hold_prev = (out_valid && !out_ready) || !en;
      prev_snap = {out_valid, out_slice_last, out_last, out_data};
    end
  end

  // Called at 3 ns past a rising edge; leaves the DUT freshly reset.
  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    feed_active = 1'b0;
    @(posedge clk); #3;
    check("rst_zero", {out_valid, out_slice_last, out_last, done, in_ready, out_data}, '0);
    exp_idx   = 0;
    last_cnt  = 0;
    slice_cnt = 0;
    feed_row  = 0;
    acc_seen  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_idx(input int target);
    for (int t = 0; t < BOUND && exp_idx < target; t++) begin
      @(posedge clk); #3;
    end
    check("wait_idx_timeout", exp_idx >= target, 1'b1);
  endtask

  task automatic wait_rows(input int target);
    for (int t = 0; t < BOUND && feed_row < target; t++) begin
      @(posedge clk); #3;
    end
    check("wait_rows_timeout", feed_row >= target, 1'b1);
  endtask

  task automatic wait_done();
    for (int t = 0; t < BOUND && !done; t++) begin
      @(posedge clk); #3;
    end
    check("done", done, 1'b1);
    check("words", exp_idx, TOTAL);
    check("last_count", last_cnt, 1);
    check("slice_count", slice_cnt, NG);
    check("rows_used", feed_row, ROWS);
    check("done_valid_low", out_valid, 1'b0);
  endtask

  task automatic stall5();
    en = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    en = 1'b1;
  endtask

  function automatic logic [63:0] small_row(input int r);
    logic [63:0] v;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = 16'(4 * r + c);
    return v;
  endfunction

  int          e0_tab [9];
  logic [63:0] s_got  [4];
  logic [1:0]  s_flag [4];
  logic [63:0] s_exp  [4];
  logic [1:0]  s_fexp [4];
  int          sr, sw;

  initial begin
    rst = 1'b1; en = 1'b0;
    s_rst = 1'b1; s_en = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    e0_tab = '{0, 1, 64, 65, 128, 129, 192, 193, 2};
    s_exp  = '{{16'd5, 16'd4, 16'd1, 16'd0}, {16'd7, 16'd6, 16'd3, 16'd2},
               {16'd13, 16'd12, 16'd9, 16'd8}, {16'd15, 16'd14, 16'd11, 16'd10}};
    s_fexp = '{2'b00, 2'b10, 2'b00, 2'b11};

    // Small geometry: two groups of two words.
    @(posedge clk); #1;
    s_rst = 1'b0;
    sr = 0;
    sw = 0;
    for (int t = 0; t < 60 && sw < 4; t++) begin
      s_in_valid = (sr < 4);
      s_in_data  = small_row(sr);
      @(negedge clk);
      if (s_out_valid) begin
        s_got[sw]  = s_out_data;
        s_flag[sw] = {s_out_slice_last, s_out_last};
        sw++;
      end
      if (s_in_valid && s_in_ready) sr++;
      @(posedge clk); #1;
    end
    check("small_count", sw, 4);
    for (int i = 0; i < sw && i < 4; i++) begin
      check("small_word", s_got[i], s_exp[i]);
      check("small_flags", s_flag[i], s_fexp[i]);
    end
    check("small_done", s_done, 1'b1);

    @(posedge clk); #3;

    // Ramp matrix, consumer always ready.
    do_reset();
    mode = 0; gap_pct = 0; ready_pct = 100;
    feed_active = 1'b1;
    wait_done();
    for (int i = 0; i < 9; i++) check("w0_elem", cap_w0[i*W +: W], 16'(e0_tab[i]));
    check("w1_elem0", cap_w1[0 +: W], 16'd4);

    // Ramp matrix, random back-pressure.
    do_reset();
    mode = 0; gap_pct = 0; ready_pct = 50;
    feed_active = 1'b1;
    wait_done();

    // Random matrix, input gaps and back-pressure.
    do_reset();
    mode = 1; seed = int'($urandom); gap_pct = 40; ready_pct = 50;
    feed_active = 1'b1;
    wait_done();

    // Enable stalls mid-emit and mid-fill.
    do_reset();
    mode = 1; seed = int'($urandom); gap_pct = 20; ready_pct = 70;
    feed_active = 1'b1;
    wait_idx(20);
    stall5();
    wait_rows(130);
    stall5();
    wait_done();

    // Reset in the middle of group 3, then a clean full run.
    do_reset();
    mode = 0; gap_pct = 0; ready_pct = 100;
    feed_active = 1'b1;
    wait_idx(3 * SW + 8);
    do_reset();
    feed_active = 1'b1;
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
